atto_cfg_loader: RTL

ATTO_CFG_LOADER -- requirements
Module: atto_cfg_loader

---
 rtl/atto_cfg_pkg.sv | 17 +
 rtl/atto_crc8.sv | 24 ++
 rtl/atto_cfg_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/atto_cfg_pkg.sv
// rtl/atto_cfg_pkg.sv - shared states and constants for the config-chain loader
package atto_cfg_pkg;

  localparam int CHAIN_BITS_DEFAULT = 128;
  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT,
    WAIT_CRC,
    LATCH,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/atto_crc8.sv
// rtl/atto_crc8.sv - byte-wide CRC-8 update (MSB-first, non-reflected)
module atto_crc8
  import atto_cfg_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  // Fold the byte into the remainder, then run eight polynomial steps
  always_comb begin
    logic [7:0] c;
    c = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/atto_cfg_loader.sv
// rtl/atto_cfg_loader.sv - bytestream to serial config-chain loader; ATTO_CFG_CRC_EN adds a trailing CRC-8 check
module atto_cfg_loader
  import atto_cfg_pkg::*;
#(
  parameter int CHAIN_BITS = CHAIN_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cfg_shift,
  output logic       cfg_bit,
  output logic       cfg_latch,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int NBYTES = CHAIN_BITS / 8;
  localparam int CNT_W  = $clog2(NBYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES);

  state_t           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign accept = in_valid & in_ready;

`ifdef ATTO_CFG_CRC_EN
  logic [7:0] crc_q, crc_d, crc_next;

  atto_crc8 u_crc8 (
    .crc_i  (crc_q),
    .data_i (in_data),
    .crc_o  (crc_next)
  );

  // Running CRC over the data bytes of the current load
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end
`endif

  // State, shift register and counters; rst abandons any partial load
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Moore outputs; a byte shifts out LSB first over 8 cycles
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    cfg_shift = 1'b0;
    cfg_bit   = 1'b0;
    cfg_latch = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
`ifdef ATTO_CFG_CRC_EN
    crc_d     = crc_q;
`endif
    unique case (state_q)
      IDLE, DONE, ERR: begin
        done = (state_q == DONE);
`ifdef ATTO_CFG_CRC_EN
        err  = (state_q == ERR);
`endif
        if (start) begin
          state_d = WAIT_BYTE;
          cnt_d   = '0;
`ifdef ATTO_CFG_CRC_EN
          crc_d   = '0;
`endif
        end
      end
      WAIT_BYTE: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (accept) begin
          sr_d    = in_data;
          bit_d   = '0;
          cnt_d   = cnt_q + 1'b1;
`ifdef ATTO_CFG_CRC_EN
          crc_d   = crc_next;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        cfg_shift = 1'b1;
        cfg_bit   = sr_q[0];
        sr_d      = {1'b0, sr_q[7:1]};
        bit_d     = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          if (cnt_q == LAST_BYTE) begin
`ifdef ATTO_CFG_CRC_EN
            state_d = WAIT_CRC;
`else
            state_d = LATCH;
`endif
          end else begin
            state_d = WAIT_BYTE;
          end
        end
      end
      WAIT_CRC: begin
`ifdef ATTO_CFG_CRC_EN
        busy     = 1'b1;
        in_ready = 1'b1;
        if (accept) begin
          state_d = (in_data == crc_q) ? LATCH : ERR;
        end
`else
        state_d = IDLE;
`endif
      end
      LATCH: begin
        busy      = 1'b1;
        cfg_latch = 1'b1;
        state_d   = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
